// File: rtl/test_ram_arbiter.sv
// test_ram_arbiter
//   Round-robin arbiter sharing one single-ported test RAM (registered read,
//   1-cycle latency) between two requesters. A port may hold the RAM for up to
//   MAX_BURST consecutive grants while the other port is also requesting; a
//   lone requester is never stalled.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_i, we_i [1:0]        per-port request / write enable
//   addrN_i, wdataN_i, beN_i per-port address, write data, byte enables
//   gnt_o [1:0]              per-port grant (combinational, one-hot or zero)
//   rvalid_o [1:0]           per-port read-data valid, 1 cycle after grant
//   rdata_o                  read data broadcast to both ports
//   mem_*_o                  RAM request/command muxed from the granted port
//   mem_rdata_i              RAM read data, valid 1 cycle after a read
module test_ram_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [1:0]              req_i,
  input  logic [1:0]              we_i,
  input  logic [ADDR_WIDTH-1:0]   addr0_i,
  input  logic [ADDR_WIDTH-1:0]   addr1_i,
  input  logic [DATA_WIDTH-1:0]   wdata0_i,
  input  logic [DATA_WIDTH-1:0]   wdata1_i,
  input  logic [DATA_WIDTH/8-1:0] be0_i,
  input  logic [DATA_WIDTH/8-1:0] be1_i,
  output logic [1:0]              gnt_o,
  output logic [1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;     // 0 = port 0, 1 = port 1
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      owner_q  <= OWN_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;                 // port 0 wins the first contention
      rvalid_q <= 2'b00;                // reads in flight at reset are dropped
    end else begin
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Grant decision and next-state
  always_comb begin
    gnt      = 2'b00;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rvalid_d = 2'b00;

    if (rst_ni) begin
      unique case (req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          // Owner keeps the RAM until its burst budget is spent; from idle
          // the port that was not served most recently goes first.
          if (owner_q == OWN_P0)
            gnt = (cnt_q < MAX_CNT) ? 2'b01 : 2'b10;
          else if (owner_q == OWN_P1)
            gnt = (cnt_q < MAX_CNT) ? 2'b10 : 2'b01;
          else
            gnt = last_q ? 2'b01 : 2'b10;
        end
        default: gnt = 2'b00;
      endcase
    end

    if (gnt == 2'b00) begin
      owner_d = OWN_IDLE;
      cnt_d   = '0;
    end else begin
      if ((gnt[0] && owner_q == OWN_P0) || (gnt[1] && owner_q == OWN_P1)) begin
        cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + ONE_CNT;
      end else begin
        owner_d = gnt[1] ? OWN_P1 : OWN_P0;
        cnt_d   = ONE_CNT;
      end
      last_d = gnt[1];
    end

    rvalid_d = gnt & ~we_i;
  end

  // RAM command mux: everything is zero when nobody is granted
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (gnt[0]) begin
      mem_we_o    = we_i[0];
      mem_addr_o  = addr0_i;
      mem_wdata_o = wdata0_i;
      mem_be_o    = be0_i;
    end else if (gnt[1]) begin
      mem_we_o    = we_i[1];
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
      mem_be_o    = be1_i;
    end
  end

  assign gnt_o     = gnt;
  assign mem_req_o = gnt[0] | gnt[1];
  assign rvalid_o  = rvalid_q;
  assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_test_ram_arbiter.sv
module tb_test_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, we;
  logic [63:0] addr0, addr1, wdata0, wdata1;
  logic [7:0]  be0, be1;

  logic [1:0]  gnt [2];
  logic [1:0]  rvalid [2];
  logic [63:0] rdata [2];
  logic        mem_req [2];
  logic        mem_we [2];
  logic [63:0] mem_addr [2];
  logic [63:0] mem_wdata [2];
  logic [7:0]  mem_be [2];
  logic [63:0] ram_rd [2];
  logic [63:0] ram [2][256];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  // Instance 0: MAX_BURST = 4, instance 1: MAX_BURST = 1; same stimulus.
  test_ram_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_BURST(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .be0_i(be0), .be1_i(be1), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]), .mem_be_o(mem_be[0]),
    .mem_rdata_i(ram_rd[0]));

  test_ram_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .MAX_BURST(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .be0_i(be0), .be1_i(be1), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]), .mem_be_o(mem_be[1]),
    .mem_rdata_i(ram_rd[1]));

  // Single-ported RAMs behind each arbiter; cleared while reset is low.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < 256; i++) ram[d][i] <= '0;
      end else if (mem_req[d]) begin
        if (mem_we[d]) begin
          for (int b = 0; b < 8; b++)
            if (mem_be[d][b]) ram[d][mem_addr[d][10:3]][b*8 +: 8] <= mem_wdata[d][b*8 +: 8];
        end else begin
          ram_rd[d] <= ram[d][mem_addr[d][10:3]];
        end
      end
    end
  end

  // ---------------- reference model ----------------
  int          maxb [2] = '{4, 1};
  int          m_prev [2];     // port served last cycle, -1 if none
  int          m_streak [2];   // consecutive cycles that port has been served
  int          m_last [2];     // most recently served port
  logic [1:0]  m_rv [2];
  logic [63:0] m_rd [2];
  logic [63:0] mmem [2][256];

  function automatic int model_gnt(int d);
    if (!rst_n || req == 2'b00) return -1;
    if (req == 2'b01) return 0;
    if (req == 2'b10) return 1;
    if (m_prev[d] >= 0)
      return (m_streak[d] >= maxb[d]) ? 1 - m_prev[d] : m_prev[d];
    return 1 - m_last[d];
  endfunction

  task automatic model_advance();
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [63:0] a, wd;
      logic [7:0] bm;
      g = model_gnt(d);
      m_rv[d] = 2'b00;
      if (!rst_n) begin
        m_prev[d] = -1; m_streak[d] = 0; m_last[d] = 1;
        for (int i = 0; i < 256; i++) mmem[d][i] = '0;
      end else if (g < 0) begin
        m_prev[d] = -1; m_streak[d] = 0;
      end else begin
        a  = (g == 1) ? addr1 : addr0;
        wd = (g == 1) ? wdata1 : wdata0;
        bm = (g == 1) ? be1 : be0;
        if (we[g]) begin
          for (int b = 0; b < 8; b++)
            if (bm[b]) mmem[d][a[10:3]][b*8 +: 8] = wd[b*8 +: 8];
        end else begin
          m_rv[d][g] = 1'b1;
          m_rd[d] = mmem[d][a[10:3]];
        end
        m_streak[d] = (g == m_prev[d]) ? m_streak[d] + 1 : 1;
        m_prev[d] = g;
        m_last[d] = g;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int d = 0; d < 2; d++) begin
      int g;
      logic [1:0] eg;
      g = model_gnt(d);
      eg = (g < 0) ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
      chk($sformatf("d%0d gnt", d), 64'(gnt[d]), 64'(eg));
      chk($sformatf("d%0d mem_req", d), 64'(mem_req[d]), 64'(g >= 0));
      chk($sformatf("d%0d mem_we", d), 64'(mem_we[d]), (g < 0) ? 64'd0 : 64'(we[g]));
      chk($sformatf("d%0d mem_addr", d), mem_addr[d], (g < 0) ? 64'd0 : (g == 1 ? addr1 : addr0));
      chk($sformatf("d%0d mem_wdata", d), mem_wdata[d], (g < 0) ? 64'd0 : (g == 1 ? wdata1 : wdata0));
      chk($sformatf("d%0d mem_be", d), 64'(mem_be[d]), (g < 0) ? 64'd0 : 64'(g == 1 ? be1 : be0));
      chk($sformatf("d%0d rvalid", d), 64'(rvalid[d]), 64'(m_rv[d]));
      if (m_rv[d] != 2'b00) chk($sformatf("d%0d rdata", d), rdata[d], m_rd[d]);
    end
  endtask

  // One clock: model follows the edge, new inputs after it, check mid-cycle.
  task automatic cycle(input logic r, input logic [1:0] rq, input logic [1:0] w,
                       input logic [63:0] a0, input logic [63:0] a1,
                       input logic [63:0] d0, input logic [63:0] d1,
                       input logic [7:0] b0, input logic [7:0] b1);
    @(posedge clk);
    model_advance();
    #1;
    rst_n = r; req = rq; we = w; addr0 = a0; addr1 = a1;
    wdata0 = d0; wdata1 = d1; be0 = b0; be1 = b1;
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        rst;
    logic [1:0]  req, we;
    logic [63:0] a0, a1, d0;
    logic [7:0]  b0;
    logic [1:0]  g4, g1, rv4;
    logic        chk_rd;
    logic [63:0] rd;
  } vec_t;

  localparam logic [63:0] PAT = 64'h0123_4567_89AB_CDEF;
  vec_t vecs [22];

  initial begin
    logic [1:0]  g4_now;
    logic [1:0]  prev1;
    int          g4;
    logic [1:0]  nrq, nwe;
    logic [63:0] na0, na1, nd0, nd1;
    logic [7:0]  nb0, nb1;
    logic        nr;
    int          seq4 [12] = '{0,0,0,0,1,1,1,1,0,0,0,0};

    rst_n = 1'b0; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
    for (int d = 0; d < 2; d++) begin
      m_prev[d] = -1; m_streak[d] = 0; m_last[d] = 1; m_rv[d] = '0; m_rd[d] = '0;
      for (int i = 0; i < 256; i++) mmem[d][i] = '0;
    end

    //               rst req    we     a0      a1      d0   b0     g4     g1     rv4    chk rd
    vecs[0]  = '{1'b0, 2'b00, 2'b00, 64'h0,  64'h0,  64'h0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 2'b11, 2'b00, 64'h0,  64'h0,  64'h0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 2'b01, 2'b01, 64'h8,  64'h0,  PAT,   8'hFF, 2'b01, 2'b01, 2'b00, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 2'b01, 2'b00, 64'h8,  64'h0,  64'h0, 8'hFF, 2'b01, 2'b01, 2'b00, 1'b0, 64'h0};
    vecs[4]  = '{1'b1, 2'b00, 2'b00, 64'h0,  64'h0,  64'h0, 8'h00, 2'b00, 2'b00, 2'b01, 1'b1, PAT};
    vecs[5]  = '{1'b1, 2'b00, 2'b00, 64'h0,  64'h0,  64'h0, 8'h00, 2'b00, 2'b00, 2'b00, 1'b0, 64'h0};
    vecs[6]  = '{1'b1, 2'b11, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b10, 2'b10, 2'b00, 1'b0, 64'h0};
    vecs[7]  = '{1'b1, 2'b11, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b10, 2'b01, 2'b10, 1'b0, 64'h0};
    vecs[8]  = '{1'b1, 2'b11, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b10, 2'b10, 2'b10, 1'b0, 64'h0};
    vecs[9]  = '{1'b1, 2'b11, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b10, 2'b01, 2'b10, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 2'b11, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b01, 2'b10, 2'b10, 1'b0, 64'h0};
    for (int i = 11; i <= 20; i++)
      vecs[i] = '{1'b1, 2'b10, 2'b00, 64'h10, 64'h18, 64'h0, 8'hFF, 2'b10, 2'b10,
                  (i == 11) ? 2'b01 : 2'b10, 1'b0, 64'h0};
    vecs[21] = '{1'b1, 2'b00, 2'b00, 64'h0,  64'h0,  64'h0, 8'h00, 2'b00, 2'b00, 2'b10, 1'b0, 64'h0};

    for (int i = 0; i < 22; i++) begin
      cycle(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1,
            vecs[i].d0, 64'h0, vecs[i].b0, 8'hFF);
      chk($sformatf("vec%0d gnt4", i), 64'(gnt[0]), 64'(vecs[i].g4));
      chk($sformatf("vec%0d gnt1", i), 64'(gnt[1]), 64'(vecs[i].g1));
      chk($sformatf("vec%0d rvalid4", i), 64'(rvalid[0]), 64'(vecs[i].rv4));
      if (vecs[i].chk_rd) chk($sformatf("vec%0d rdata4", i), rdata[0], vecs[i].rd);
    end

    // Reset arriving on the edge that ends a read grant drops that read.
    cycle(1'b1, 2'b01, 2'b00, 64'h8, 64'h0, 64'h0, 64'h0, 8'hFF, 8'hFF);
    chk("rst_rd gnt4", 64'(gnt[0]), 64'(2'b01));
    chk("rst_rd gnt1", 64'(gnt[1]), 64'(2'b01));
    #1;
    rst_n = 1'b0; req = 2'b00;
    cycle(1'b0, 2'b00, 2'b00, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 8'h00);
    chk("rst_rd rvalid4", 64'(rvalid[0]), 64'(2'b00));
    chk("rst_rd rvalid1", 64'(rvalid[1]), 64'(2'b00));
    chk("rst_rd gnt_low", 64'(gnt[0]), 64'(2'b00));

    // Contention straight out of reset: burst pattern and strict alternation.
    prev1 = 2'b00;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 2'b11, 2'b00, 64'h8, 64'h20, 64'h0, 64'h0, 8'hFF, 8'hFF);
      chk($sformatf("cont%0d gnt4", i), 64'(gnt[0]), 64'(seq4[i] ? 2'b10 : 2'b01));
      chk($sformatf("cont%0d gnt1", i), 64'(gnt[1]), 64'((i % 2) ? 2'b10 : 2'b01));
      chk($sformatf("cont%0d mem_req4", i), 64'(mem_req[0]), 64'd1);
      if (i > 0) chk($sformatf("cont%0d rvalid1", i), 64'(rvalid[1]), 64'(prev1));
      prev1 = gnt[1];
    end

    // Randomised traffic; a pending request is held until port-4 grants it.
    for (int n = 0; n < 600; n++) begin
      g4 = model_gnt(0);
      g4_now = gnt[0];
      nr = ($urandom_range(0, 63) != 0);
      nrq = req; nwe = we; na0 = addr0; na1 = addr1;
      nd0 = wdata0; nd1 = wdata1; nb0 = be0; nb1 = be1;
      if (!(req[0] && g4 != 0) || g4_now == 2'b11) begin
        nrq[0] = ($urandom_range(0, 3) != 0);
        nwe[0] = $urandom_range(0, 1);
        na0 = 64'($urandom_range(0, 15)) << 3;
        nd0 = {$urandom, $urandom};
        nb0 = 8'($urandom);
      end
      if (!(req[1] && g4 != 1)) begin
        nrq[1] = ($urandom_range(0, 3) != 0);
        nwe[1] = $urandom_range(0, 1);
        na1 = 64'($urandom_range(0, 15)) << 3;
        nd1 = {$urandom, $urandom};
        nb1 = 8'($urandom);
      end
      cycle(nr, nrq, nwe, na0, na1, nd0, nd1, nb0, nb1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
